seq_divider: RTL

Parametrised, multi-cycle integer divider with a start/done handshake. It produces quotient and remainder for signed or unsigned operands of configurable width, one restoring-division iteration per clock. It flags divide-by-zero and signed overflow on fast paths. It sits between operand registers and the result/display path of the lab datapath, replacing the fixed 8-bit combinational divider where timing or width demands it.

---
 rtl/divider_pkg.sv | 17 +
 rtl/div_step.sv | 29 ++
 rtl/seq_divider.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/divider_pkg.sv
// Shared types and sizing helpers for the sequential restoring divider.
package divider_pkg;

    // Controller states of the divider
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2,
        FAST = 2'd3
    } state_t;

    // Bits needed to count 0..w iterations
    function automatic int unsigned cnt_width(input int unsigned w);
        return $clog2(w + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_step #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] dmag,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    // Shifted partial remainder needs one extra bit before the compare
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] diff;

    // Shift {rem,quo} left, subtract the divisor when it fits
    always_comb begin
        rem_sh = {rem, quo[WIDTH-1]};
        diff   = rem_sh - {1'b0, dmag};
        if (rem_sh >= {1'b0, dmag}) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = rem_sh[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned divider with start/done handshake and
// single-cycle fast paths for divide-by-zero and MIN / -1.
module seq_divider
    import divider_pkg::*;
#(
    parameter int unsigned WIDTH  = 8,
    parameter bit          SIGNED = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             busy,
    output logic             done,
    output logic             divide_by_zero,
    output logic             overflow
);

    localparam int unsigned    CW       = cnt_width(WIDTH);
    localparam logic [CW-1:0]  LAST_CNT = CW'(WIDTH - 1);
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    state_t           state;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] dmag_r;
    logic [WIDTH-1:0] fast_val;
    logic [CW-1:0]    count;
    logic             neg_q;
    logic             neg_r;
    logic             fast_dz;

    logic             a_neg_c;
    logic             b_neg_c;
    logic [WIDTH-1:0] a_mag_c;
    logic [WIDTH-1:0] b_mag_c;
    logic             ovf_case_c;
    logic [WIDTH-1:0] rem_nx;
    logic [WIDTH-1:0] quo_nx;

    // Operand signs and unsigned magnitudes; |MIN| stays MIN as unsigned
    always_comb begin
        a_neg_c    = SIGNED && dividend[WIDTH-1];
        b_neg_c    = SIGNED && divisor[WIDTH-1];
        a_mag_c    = a_neg_c ? WIDTH'(-dividend) : dividend;
        b_mag_c    = b_neg_c ? WIDTH'(-divisor) : divisor;
        ovf_case_c = SIGNED && (dividend == MIN_VAL) && (divisor == '1);
    end

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem      (rem_r),
        .quo      (quo_r),
        .dmag     (dmag_r),
        .rem_next (rem_nx),
        .quo_next (quo_nx)
    );

    // Controller, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            rem_r          <= '0;
            quo_r          <= '0;
            dmag_r         <= '0;
            fast_val       <= '0;
            count          <= '0;
            neg_q          <= 1'b0;
            neg_r          <= 1'b0;
            fast_dz        <= 1'b0;
            quotient       <= '0;
            remainder      <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
            divide_by_zero <= 1'b0;
            overflow       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            state    <= FAST;
                            fast_dz  <= 1'b1;
                            fast_val <= dividend;
                        end else if (ovf_case_c) begin
                            state    <= FAST;
                            fast_dz  <= 1'b0;
                            fast_val <= dividend;
                        end else begin
                            state  <= RUN;
                            rem_r  <= '0;
                            quo_r  <= a_mag_c;
                            dmag_r <= b_mag_c;
                            neg_q  <= a_neg_c ^ b_neg_c;
                            neg_r  <= a_neg_c;
                            count  <= '0;
                        end
                    end
                end
                RUN: begin
                    rem_r <= rem_nx;
                    quo_r <= quo_nx;
                    count <= count + CW'(1);
                    if (count == LAST_CNT) begin
                        state <= FIX;
                    end
                end
                FIX: begin
                    quotient       <= neg_q ? WIDTH'(-quo_r) : quo_r;
                    remainder      <= neg_r ? WIDTH'(-rem_r) : rem_r;
                    divide_by_zero <= 1'b0;
                    overflow       <= 1'b0;
                    done           <= 1'b1;
                    busy           <= 1'b0;
                    state          <= IDLE;
                end
                FAST: begin
                    if (fast_dz) begin
                        quotient       <= '0;
                        remainder      <= fast_val;
                        divide_by_zero <= 1'b1;
                        overflow       <= 1'b0;
                    end else begin
                        quotient       <= fast_val;
                        remainder      <= '0;
                        divide_by_zero <= 1'b0;
                        overflow       <= 1'b1;
                    end
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
